// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code constants, legality check and the request /
// response records passed between the arbiter, its response slots and the ALU.
package alu_pkg;

  localparam int ALU_W      = 16;
  localparam int ALU_CTRL_W = 5;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = 5'h00;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = 5'h01;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND   = 5'h02;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR    = 5'h03;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = 5'h04;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL   = 5'h05;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA   = 5'h06;
  localparam logic [ALU_CTRL_W-1:0] ALU_RSVD7 = 5'h07;
  localparam logic [ALU_CTRL_W-1:0] ALU_LLB   = 5'h08;
  localparam logic [ALU_CTRL_W-1:0] ALU_LHB   = 5'h09;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD_A = 5'h0A;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD_B = 5'h0B;

  typedef struct packed {
    logic [ALU_W-1:0]      a;
    logic [ALU_W-1:0]      b;
    logic [ALU_CTRL_W-1:0] ctrl;
  } alu_req_t;

  typedef struct packed {
    logic [ALU_W-1:0] data;
    logic             ovfl;
    logic             err;
  } alu_resp_t;

  typedef enum logic {
    GRANT_P0 = 1'b0,
    GRANT_P1 = 1'b1
  } grant_e;

  // Everything above ALU_ADD_B is reserved, as is the hole at 0x07.
  function automatic logic alu_op_legal(input logic [ALU_CTRL_W-1:0] ctrl);
    return (ctrl <= ALU_ADD_B) && (ctrl != ALU_RSVD7);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU. Overflow is signed two's-complement overflow and is
// only meaningful for the add/sub classes; illegal op codes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic [W-1:0]          i_a,
  input  logic [W-1:0]          i_b,
  input  logic [ALU_CTRL_W-1:0] i_ctrl,
  output logic [W-1:0]          o_result,
  output logic                  o_ovfl
);

  localparam int SHW = $clog2(W);
  localparam int HW  = W / 2;

  logic [W-1:0]   w_sum;
  logic [W-1:0]   w_diff;
  logic [SHW-1:0] w_shamt;

  assign w_sum   = i_a + i_b;
  assign w_diff  = i_a - i_b;
  assign w_shamt = i_b[SHW-1:0];

  always_comb begin
    o_result = '0;
    o_ovfl   = 1'b0;
    case (i_ctrl)
      ALU_ADD, ALU_ADD_A, ALU_ADD_B: begin
        o_result = w_sum;
        o_ovfl   = (i_a[W-1] == i_b[W-1]) && (w_sum[W-1] != i_a[W-1]);
      end
      ALU_SUB: begin
        o_result = w_diff;
        o_ovfl   = (i_a[W-1] != i_b[W-1]) && (w_diff[W-1] != i_a[W-1]);
      end
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_SLL: o_result = i_a << w_shamt;
      ALU_SRA: o_result = $signed(i_a) >>> w_shamt;
      // Byte loads keep the other half of operand a.
      ALU_LLB: o_result = {i_a[W-1:HW], i_b[HW-1:0]};
      ALU_LHB: o_result = {i_b[HW-1:0], i_a[HW-1:0]};
      default: begin
        o_result = '0;
        o_ovfl   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_resp_slot.sv
// One-deep response register for a single requester. A load wins over a drain,
// so load-and-drain in the same cycle replaces the contents and stays valid.
module alu_resp_slot
  import alu_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_load,
  input  alu_resp_t i_load_resp,
  input  logic      i_drain_ready,
  output logic      o_valid,
  output logic      o_space,
  output alu_resp_t o_resp
);

  logic      r_valid;
  alu_resp_t r_resp;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_resp  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_resp  <= i_load_resp;
    end else if (r_valid && i_drain_ready) begin
      r_valid <= 1'b0;
      r_resp  <= '0;
    end
  end

  // The slot can take a new result if it is empty or being drained this cycle.
  assign o_space = !r_valid || i_drain_ready;
  assign o_valid = r_valid;
  assign o_resp  = r_resp;

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of the shared ALU with per-requester response
// slots. Define ALU_ARB_RR_EN for round-robin; otherwise requester 0 has fixed priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int W     = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [N_REQ-1:0]                 i_req_valid,
  output logic [N_REQ-1:0]                 o_req_ready,
  input  logic [N_REQ-1:0][W-1:0]          i_req_a,
  input  logic [N_REQ-1:0][W-1:0]          i_req_b,
  input  logic [N_REQ-1:0][ALU_CTRL_W-1:0] i_req_ctrl,
  output logic [N_REQ-1:0]                 o_resp_valid,
  input  logic [N_REQ-1:0]                 i_resp_ready,
  output logic [N_REQ-1:0][W-1:0]          o_resp_data,
  output logic [N_REQ-1:0]                 o_resp_ovfl,
  output logic [N_REQ-1:0]                 o_resp_err,
  output logic                             o_last_grant
);

  if (N_REQ != 2) begin : g_bad_n_req
    $error("alu_arbiter: N_REQ must be 2");
  end
  if (W != ALU_W) begin : g_bad_w
    $error("alu_arbiter: W must match the ALU width");
  end

  logic [N_REQ-1:0] w_space;
  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_grant;
  grant_e           r_last_grant;
  alu_req_t         w_alu_req;
  alu_resp_t        w_load_resp;
  logic [W-1:0]     w_alu_result;
  logic             w_alu_ovfl;

  // Nothing is granted during reset so no handshake completes in that cycle.
  assign w_elig = i_rst ? '0 : (i_req_valid & w_space);

  always_comb begin
    w_grant = '0;
    if (w_elig[0] && w_elig[1]) begin
`ifdef ALU_ARB_RR_EN
      w_grant = (r_last_grant == GRANT_P0) ? 2'b10 : 2'b01;
`else
      w_grant = 2'b01;
`endif
    end else begin
      w_grant = w_elig;
    end
  end

  assign o_req_ready  = w_grant;
  assign o_last_grant = r_last_grant;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= GRANT_P1;
    end else if (w_grant[1]) begin
      r_last_grant <= GRANT_P1;
    end else if (w_grant[0]) begin
      r_last_grant <= GRANT_P0;
    end
  end

  // With no grant the ALU sees all-zero operands.
  always_comb begin
    w_alu_req = '0;
    if (w_grant[0]) begin
      w_alu_req.a    = i_req_a[0];
      w_alu_req.b    = i_req_b[0];
      w_alu_req.ctrl = i_req_ctrl[0];
    end else if (w_grant[1]) begin
      w_alu_req.a    = i_req_a[1];
      w_alu_req.b    = i_req_b[1];
      w_alu_req.ctrl = i_req_ctrl[1];
    end
  end

  alu #(
    .W(W)
  ) u_alu (
    .i_a      (w_alu_req.a),
    .i_b      (w_alu_req.b),
    .i_ctrl   (w_alu_req.ctrl),
    .o_result (w_alu_result),
    .o_ovfl   (w_alu_ovfl)
  );

  always_comb begin
    w_load_resp = '0;
    if (alu_op_legal(w_alu_req.ctrl)) begin
      w_load_resp.data = w_alu_result;
      w_load_resp.ovfl = w_alu_ovfl;
    end else begin
      w_load_resp.err = 1'b1;
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    alu_resp_t w_resp;

    alu_resp_slot u_slot (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_load        (w_grant[i]),
      .i_load_resp   (w_load_resp),
      .i_drain_ready (i_resp_ready[i]),
      .o_valid       (o_resp_valid[i]),
      .o_space       (w_space[i]),
      .o_resp        (w_resp)
    );

    assign o_resp_data[i] = w_resp.data;
    assign o_resp_ovfl[i] = w_resp.ovfl;
    assign o_resp_err[i]  = w_resp.err;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational 16-bit ALU between two requesters, for example the CPU execute stage on port 0 and the NN-accelerator address/control sequencer on port 1. Each requester presents operands and a 5-bit op code over a valid/ready handshake. The arbiter grants at most one request per cycle, drives the ALU, and registers the result into a per-requester response slot. Each slot is drained by that requester over its own valid/ready handshake.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters. Fixed at 2; any other value is a elaboration-time error.
- `W`, 16: operand/result width. Must match the ALU.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid[1:0]`  in  2  request valid, per requester
- `req_ready[1:0]`  out  2  request accepted this cycle when `req_valid & req_ready`
- `req_a[i]`, `req_b[i]`  in  16 each  operands, per requester
- `req_ctrl[i]`  in  5  ALU op code, per requester
- `resp_valid[1:0]`  out  2  response slot full
- `resp_ready[1:0]`  in  2  requester consumes its slot
- `resp_data[i]`  out  16  registered ALU result
- `resp_ovfl[i]`  out  1  registered ALU overflow
- `resp_err[i]`  out  1  op code was illegal

## Operation
- Legal op codes: 0x0 add, 0x1 sub, 0x2 and, 0x3 or, 0x4 xor, 0x5 sll, 0x6 sra, 0x8 llb, 0x9 lhb, 0xA/0xB add-class.
- Illegal op codes: 0x7 and 0xC–0x1F. These are still accepted. The response carries data 0, ovfl 0, err 1.
- Eligibility: requester i is eligible when `req_valid[i] & (!resp_valid[i] | resp_ready[i])`.
- Grant: at most one eligible requester is granted per cycle. `req_ready[i]` is 1 only for the granted requester.
  - `req_ready` may depend combinationally on `req_valid` and `resp_ready`.
  - `req_valid` must not depend on `req_ready`.
- ALU drive: the ALU inputs are muxed from the granted requester. With no grant, the ALU is driven with zeros.
- Response slot:
  - On accept, the slot loads {result, ovfl, err} and sets `resp_valid`.
  - On `resp_valid & resp_ready` with no new load, the slot clears.
  - Load and drain in the same cycle: the new data replaces the old and `resp_valid` stays 1.
- Pointer: `last_grant` (1 bit) records the most recent grant. It updates only on an accept.

## Timing
- Reset values: all `resp_valid` 0, `resp_data` 0, `resp_ovfl` 0, `resp_err` 0, `last_grant` 1 (so requester 0 has priority first). `req_ready` is 0 throughout reset.
- Latency: request accepted at edge N → `resp_valid` high and data stable immediately after edge N, i.e. visible in cycle N+1.
- Throughput: one request per cycle in aggregate. One requester alone sustains one per cycle only while it drains every cycle.
- Full-slot back-pressure: a full, undrained slot blocks that requester only. The other requester may be granted in the same cycle.
- Reset mid-operation: pending slot contents are discarded, with no response delivered. Any in-flight handshake in the reset cycle is not accepted.
- Operand stability: operands need only be valid in the accept cycle. No operand is held internally beyond the result register.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration. When both requesters are eligible, grant goes to the one not equal to `last_grant`.
- `ALU_ARB_RR_EN` undefined: fixed priority, requester 0 always wins. `last_grant` is still maintained for debug, but does not affect the grant.

## Structure
- Shared package `alu_pkg`:
  - op-code constants: `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_XOR`, `ALU_SLL`, `ALU_SRA`, `ALU_LLB`, `ALU_LHB`, `ALU_ADD_A`, `ALU_ADD_B`
  - function `alu_op_legal(ctrl)`
  - typedef `alu_req_t` {a, b, ctrl}
  - typedef `alu_resp_t` {data, ovfl, err}
- Sub-module `alu_resp_slot`: one response register with valid/ready and load/drain logic, instantiated once per requester.
- The existing ALU is instantiated once, unmodified.

## Test plan
- Single add: port 0, a=0x0003, b=0x0004, ctrl 0x0 → next cycle `resp_valid[0]`=1, data 0x0007, ovfl 0, err 0.
- Overflow: port 1, a=0x7FFF, b=0x0001, add → data 0x8000, ovfl 1. Then sub with a=0x8000, b=0x0001 → data 0x7FFF, ovfl 1.
- Contention:
  - Both ports valid for 4 cycles with `resp_ready` held 1.
  - RR build: grants 0,1,0,1.
  - Fixed-priority build: grants 0,0,0,0, and port 1 is starved until port 0 drops valid.
- Back-pressure:
  - Port 0 `resp_ready`=0 after its first response → `req_ready[0]`=0 while port 1 is still granted.
  - Raise `resp_ready[0]` → same-cycle re-accept, and the slot shows the new data.
- Illegal op: ctrl 0x07 and ctrl 0x1F with a=0xFFFF → data 0x0000, ovfl 0, err 1.
- Reset mid-flight:
  - Assert `rst` with both slots full → next cycle `resp_valid`=00 and all outputs 0.
  - First grant after reset goes to port 0.
